// File: rtl/mc_tg_pkg.sv
// rtl/mc_tg_pkg.sv - shared types, command layout and pattern/decode helpers for the traffic generator
package mc_tg_pkg;

    localparam int CMD_W = 34;

    typedef enum logic [1:0] {
        MODE_SEQ  = 2'd0,
        MODE_IL   = 2'd1,
        MODE_RO   = 2'd2,
        MODE_RSVD = 2'd3
    } tg_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PASS,
        ST_IL_WR,
        ST_IL_RD,
        ST_RD_PASS,
        ST_DRAIN,
        ST_DONE
    } tg_state_e;

    typedef struct packed {
        logic [1:0]  rank;
        logic [2:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
    } tg_addr_t;

    function automatic logic [31:0] tg_pattern(input logic [31:0] seed, input logic [31:0] idx,
                                               input logic [31:0] k);
        return seed + idx * 32'h9E3779B9 + k;
    endfunction

    // Column (in BL8 steps) is the fastest-moving field, then row, bank, rank.
    function automatic tg_addr_t tg_decode(input logic [31:0] idx, input int row_bits,
                                           input int col_bits, input int bank_bits,
                                           input int rank_bits);
        logic [31:0] v;
        tg_addr_t    a;
        v      = idx;
        a.col  = 10'((v & ((32'd1 << (col_bits - 3)) - 32'd1)) << 3);
        v      = v >> (col_bits - 3);
        a.row  = 13'(v & ((32'd1 << row_bits) - 32'd1));
        v      = v >> row_bits;
        a.bank = 3'(v & ((32'd1 << bank_bits) - 32'd1));
        v      = v >> bank_bits;
        a.rank = 2'(v & ((32'd1 << rank_bits) - 32'd1));
        return a;
    endfunction

    function automatic logic [CMD_W-1:0] tg_cmd(input logic rw, input tg_addr_t a);
        logic [CMD_W-1:0] c;
        c          = '0;
        c[33:32]   = a.rank;
        c[31]      = rw;
        c[29:17]   = a.row;
        c[15]      = 1'b1;
        c[12:3]    = a.col;
        c[2:0]     = a.bank;
        return c;
    endfunction

endpackage

// File: rtl/mc_tg_exp_fifo.sv
// rtl/mc_tg_exp_fifo.sv - expected-index FIFO tracking reads in flight
module mc_tg_exp_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A push on a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mc_traffic_gen.sv
// rtl/mc_traffic_gen.sv - DDR3 controller traffic generator with in-order read-back checker
module mc_traffic_gen
    import mc_tg_pkg::*;
#(
    parameter int  DATA_W      = 128,
    parameter int  ROW_BITS    = 10,
    parameter int  COL_BITS    = 4,
    parameter int  BANK_CNT    = 1,
    parameter int  RANK_CNT    = 1,
    parameter int  OUTSTANDING = 16,
    parameter int  TIMEOUT     = 4096,
    localparam int IDX_W       = ROW_BITS + COL_BITS - 3 + $clog2(BANK_CNT) + $clog2(RANK_CNT)
) (
    input  logic              clk,
    input  logic              power_on_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [31:0]       seed,
    output logic [33:0]       command,
    output logic              valid,
    output logic [DATA_W-1:0] write_data,
    input  logic [7:0]        ba_cmd_pm,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_data_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [31:0]       rd_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic              first_err_valid
);
    localparam int WORDS = DATA_W / 32;
    localparam int BB    = $clog2(BANK_CNT);
    localparam int KB    = $clog2(RANK_CNT);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    tg_state_e         state;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       seed_r;
    logic [TO_W-1:0]   idle_cnt;
    tg_addr_t          addr;
    logic [DATA_W-1:0] wr_pat;
    logic [DATA_W-1:0] exp_data;
    logic              issue_wr;
    logic              issue_rd;
    logic              start_go;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [IDX_W-1:0]  fifo_head;

    assign start_go = start && (state == ST_IDLE || state == ST_DONE);
    // Returns that arrive while idle belong to an abandoned run and are dropped silently.
    assign fifo_pop = read_data_valid && (state != ST_IDLE);

    always_comb begin
        addr     = tg_decode(32'(idx), ROW_BITS, COL_BITS, BB, KB);
        issue_wr = ba_cmd_pm[addr.bank] && (state == ST_WR_PASS || state == ST_IL_WR);
        issue_rd = ba_cmd_pm[addr.bank] && !fifo_full &&
                   (state == ST_IL_RD || state == ST_RD_PASS);
        wr_pat   = '0;
        exp_data = '0;
        for (int k = 0; k < WORDS; k++) begin
            wr_pat[k*32 +: 32]   = tg_pattern(seed_r, 32'(idx), 32'(k));
            exp_data[k*32 +: 32] = tg_pattern(seed_r, 32'(fifo_head), 32'(k));
        end
    end

    mc_tg_exp_fifo #(
        .W     (IDX_W),
        .DEPTH (OUTSTANDING)
    ) u_exp_fifo (
        .clk   (clk),
        .rst   (power_on_rst),
        .clr   (start_go),
        .push  (issue_rd),
        .pop   (fifo_pop),
        .wdata (idx),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            seed_r     <= '0;
            idle_cnt   <= '0;
            valid      <= 1'b0;
            command    <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid      <= 1'b0;
            command    <= '0;
            write_data <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        seed_r   <= seed;
                        idx      <= '0;
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        case (tg_mode_e'(mode))
                            MODE_IL: state <= ST_IL_WR;
                            MODE_RO: state <= ST_RD_PASS;
                            default: state <= ST_WR_PASS;
                        endcase
                    end
                end
                ST_WR_PASS, ST_IL_WR: begin
                    if (issue_wr) begin
                        valid      <= 1'b1;
                        command    <= tg_cmd(1'b0, addr);
                        write_data <= wr_pat;
                        if (state == ST_IL_WR) begin
                            state <= ST_IL_RD;
                        end else begin
                            idx <= idx + 1'b1;
                            if (idx == IDX_LAST) state <= ST_RD_PASS;
                        end
                    end
                end
                ST_IL_RD, ST_RD_PASS: begin
                    if (issue_rd) begin
                        valid   <= 1'b1;
                        command <= tg_cmd(1'b1, addr);
                        if (idx == IDX_LAST) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx <= idx + 1'b1;
                            if (state == ST_IL_RD) state <= ST_IL_WR;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (read_data_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            err_count       <= '0;
            rd_count        <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else if (start_go) begin
            err_count       <= '0;
            rd_count        <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else if (fifo_pop) begin
            rd_count <= rd_count + 32'd1;
            if (fifo_empty || read_data != exp_data) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= fifo_empty ? '1 : fifo_head;
                end
            end
        end
    end

endmodule
